nibble_serial_comparator: RTL



---
 rtl/nibble_serial_comparator.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_comparator.sv
// nibble_serial_comparator
// Sequential magnitude comparator. It walks both operands one nibble per
// cycle, least-significant nibble first, and feeds a single 4-bit compare
// slice through a less/greater/equal cascade state. A nibble that differs
// overrides the cascade state, so the most-significant differing nibble
// decides the result.
//
// Optional build macro: SIGNED_CMP_EN
//   defined   : two's-complement compare. Bit 3 of the most-significant
//               nibble is inverted on both operands before that nibble is
//               compared.
//   undefined : unsigned compare, and no inversion logic is built.
//
// state  | meaning
// IDLE   | waiting for start; result outputs hold the last result
// RUN    | compares nibble cnt_q, one nibble per cycle
// FINISH | copies the cascade state to the result outputs and pulses done
module nibble_serial_comparator #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic                 alb,
  output logic                 agb,
  output logic                 aeb
);

  localparam int W  = 4 * NIBBLES;
  // One spare bit, so the counter can reach NIBBLES without wrapping.
  localparam int CW = $clog2(NIBBLES) + 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FINISH
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          c_lt_q, c_lt_d;
  logic          c_gt_q, c_gt_d;
  logic          c_eq_q, c_eq_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          alb_q, alb_d;
  logic          agb_q, agb_d;
  logic          aeb_q, aeb_d;

  logic          last_nib;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;

  // The operand registers shift right once per RUN cycle, so the nibble
  // under test is always in bits 3:0.
  always_comb begin
    last_nib = (cnt_q == LAST);
`ifdef SIGNED_CMP_EN
    nib_a = last_nib ? {~a_q[3], a_q[2:0]} : a_q[3:0];
    nib_b = last_nib ? {~b_q[3], b_q[2:0]} : b_q[3:0];
`else
    nib_a = a_q[3:0];
    nib_b = b_q[3:0];
`endif
  end

  // Next-state, cascade update and output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    c_lt_d  = c_lt_q;
    c_gt_d  = c_gt_q;
    c_eq_d  = c_eq_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    alb_d   = alb_q;
    agb_d   = agb_q;
    aeb_d   = aeb_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_lt_d  = 1'b0;
          c_gt_d  = 1'b0;
          c_eq_d  = 1'b1;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (nib_a > nib_b) begin
          c_gt_d = 1'b1;
          c_lt_d = 1'b0;
          c_eq_d = 1'b0;
        end else if (nib_a < nib_b) begin
          c_lt_d = 1'b1;
          c_gt_d = 1'b0;
          c_eq_d = 1'b0;
        end
        a_d   = a_q >> 4;
        b_d   = b_q >> 4;
        cnt_d = cnt_q + CW'(1);
        if (last_nib) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        alb_d   = c_lt_q;
        agb_d   = c_gt_q;
        aeb_d   = c_eq_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      c_lt_q  <= 1'b0;
      c_gt_q  <= 1'b0;
      c_eq_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      alb_q   <= 1'b0;
      agb_q   <= 1'b0;
      aeb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_lt_q  <= c_lt_d;
      c_gt_q  <= c_gt_d;
      c_eq_q  <= c_eq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      alb_q   <= alb_d;
      agb_q   <= agb_d;
      aeb_q   <= aeb_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign alb  = alb_q;
  assign agb  = agb_q;
  assign aeb  = aeb_q;

endmodule
